// File: rtl/instr_fetch.sv
// MIPS instruction fetch stage: owns the PC, fetches over req/ack,
// holds the word in IR and steers the next PC at accept.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic [31:0] ir_q;
    logic [31:0] ir_nxt;
    logic [31:0] ret_q;
    logic [31:0] ret_nxt;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    assign pc4    = pc_q + 32'd4;
    assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    // zero is only meaningful for the held instruction at accept
    always_comb begin
        next_pc = pc4;
        unique case (1'b1)
            (ir_q[31:26] == OP_BEQ) && zero: next_pc = pc4 + br_off;
            (ir_q[31:26] == OP_J):           next_pc = {pc4[31:28], ir_q[25:0], 2'b00};
            default:                         next_pc = pc4;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
        ret_nxt   = ret_q;
        unique case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_nxt    = next_pc;
                    ret_nxt   = ret_q + 32'd1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            ret_q <= '0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            ir_q  <= ir_nxt;
            ret_q <= ret_nxt;
        end
    end

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == HOLD);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = ir_q;
    assign op          = ir_q[31:26];
    assign funct       = ir_q[5:0];
    assign retired     = ret_q;

endmodule
